muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit for the EX stage, beside the single-cycle ALU. Accepts MULT/MULTU/DIV/DIVU from the pipeline and runs a radix-2 iterative shift-add/restoring-subtract datapath. Owns the HI/LO registers and raises a pipeline stall when a new op, HI/LO read or HI/LO write arrives while an op is in flight.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_sequencer_if.sv | 32 +++
 rtl/muldiv_iter_unit.sv | 105 ++++++++++
 rtl/muldiv_sequencer.sv | 99 +++++++++
 tb/tb_muldiv_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    // Operation encoding, equal to funct[1:0] of MULT/MULTU/DIV/DIVU
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    // LO value delivered on divide by zero
    localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;

    function automatic logic op_is_div(input md_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - pipeline-side bus of the multiply/divide sequencer
// master: EX stage (drives op issue and HI/LO writes, reads HI/LO and status)
// slave : muldiv_sequencer
interface muldiv_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hilo_rd;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wdata,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_iter_unit.sv
// rtl/muldiv_iter_unit.sv - radix-2 shift-add / restoring-divide datapath with sign fix-up
// Ports: clk, reset (sync, active-high); load latches operands and op;
// step performs one iteration; res_hi/res_lo are the sign-corrected results.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic             is_div;
    logic             neg_q;     // product / quotient must be negated
    logic             neg_r;     // remainder must be negated (dividend negative)
    logic             div0;
    logic [WIDTH-1:0] raw_rs;
    logic [WIDTH-1:0] acc;       // upper product half / partial remainder
    logic [WIDTH-1:0] mq;        // multiplier -> low product, or dividend -> quotient
    logic [WIDTH-1:0] b;         // |multiplicand| or |divisor|

    logic             sgn_op;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        sgn_op  = op_is_signed(md_op_t'(op));
        abs_rs  = (sgn_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        abs_rt  = (sgn_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, b} : '0);
        shifted = {acc, mq[WIDTH-1]};
        // remainder < divisor keeps shifted < 2*divisor, so diff[WIDTH] is a pure borrow
        diff    = shifted - {1'b0, b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            raw_rs <= '0;
            acc    <= '0;
            mq     <= '0;
            b      <= '0;
        end else if (load) begin
            is_div <= op_is_div(md_op_t'(op));
            neg_q  <= sgn_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r  <= sgn_op & rs_val[WIDTH-1];
            div0   <= op_is_div(md_op_t'(op)) & (rt_val == '0);
            raw_rs <= rs_val;
            acc    <= '0;
            mq     <= abs_rs;
            b      <= abs_rt;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    acc <= diff[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shifted[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= sum[WIDTH:1];
                mq  <= {sum[0], mq[WIDTH-1:1]};
            end
        end
    end

    // Most-negative / -1 needs no special case: |q| = 2^(WIDTH-1), signs agree,
    // so the unnegated quotient is already the wrapped result with remainder 0.
    always_comb begin
        prod     = {acc, mq};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -mq : mq;
        r_fix    = neg_r ? -acc : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                res_hi = raw_rs;
                res_lo = WIDTH'(DIV0_LO);
            end else begin
                res_hi = r_fix;
                res_lo = q_fix;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Ports: clk, reset (sync, active-high), bus (muldiv_sequencer_if.slave: op issue,
// HI/LO access, busy/done/stall). Optional MULDIV_STALL_CNT_EN adds stall_cycles,
// a saturating count of stalled cycles.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
`ifdef MULDIV_STALL_CNT_EN
    output logic [31:0]         stall_cycles,
`endif
    muldiv_sequencer_if.slave   bus
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             load;
    logic             step;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign load  = (state == IDLE) && bus.start;
    assign step  = (state == CALC);
    assign busy  = (state != IDLE);
    assign stall = busy && (bus.start || bus.hilo_rd || bus.hi_we || bus.lo_we);

    assign bus.busy  = busy;
    assign bus.stall = stall;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    muldiv_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .op     (bus.op),
        .rs_val (bus.rs_val),
        .rt_val (bus.rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // an accepted op wins over a same-cycle MTHI/MTLO
                    if (bus.start) begin
                        cnt   <= CNT_W'(WIDTH - 1);
                        state <= CALC;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULDIV_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
`ifdef MULDIV_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef MULDIV_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op     = o;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // counts edges until done is seen at a negedge; also counts non-busy and stall cycles before it
    task automatic wait_done(output int n, output int not_busy, output int stall_hi);
        n = 0;
        not_busy = 0;
        stall_hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.done) break;
            if (!bus.busy) not_busy++;
            if (bus.stall) stall_hi++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n, nb, sh;
        issue(o, a, b);
        wait_done(n, nb, sh);
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy gap"}, 64'(nb), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(eh));
        check({tag, " lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        int n, nb, sh, dn;
        bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
        bus.hilo_rd = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);
        check("rst busy/done/stall", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);

        // main arithmetic vectors
        run_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        check("busy at done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("done one cycle", 64'(bus.done), 64'd0);
        run_op("mult -3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu /0", OP_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("mult max*-1", OP_MULT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("div -7/0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // hilo_rd held from E2: stall every busy cycle, released once idle
        issue(OP_MULTU, 32'd3, 32'd4);
        @(posedge clk);
        @(posedge clk);
        #1 bus.hilo_rd = 1'b1;
        wait_done(n, nb, sh);
        check("rd latency from E2", 64'(n), 64'd31);
        check("rd stall count", 64'(sh), 64'd30);
        check("rd stall at done", 64'(bus.stall), 64'd0);
        check("rd result lo", 64'(bus.lo), 64'd12);
        bus.hilo_rd = 1'b0;

        // second start in the FIX cycle
        issue(OP_MULTU, 32'd6, 32'd7);
        repeat (32) @(posedge clk);
        #1;
        bus.op = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        check("fix start stall", 64'(bus.stall), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("fix first done", 64'(bus.done), 64'd1);
        check("fix first lo", 64'(bus.lo), 64'd42);
        check("fix stall released", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(n, nb, sh);
        check("fix second latency", 64'(n), 64'd33);
        check("fix second hi/lo", {32'(bus.hi), 32'(bus.lo)}, {32'd2, 32'd14});

        // reset at E10 of a MULT aborts it
        issue(OP_MULT, 32'h1234, 32'h5678);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.hilo_rd = 1'b1;
        @(negedge clk);
        check("abort busy/stall/done", {61'd0, bus.busy, bus.stall, bus.done}, 64'd0);
        check("abort hi/lo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
        bus.hilo_rd = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort no done", 64'(dn), 64'd0);

        // MTLO, then MTHI+MTLO together while idle
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 bus.lo_we = 1'b0;
        @(negedge clk);
        check("mtlo", {32'(bus.hi), 32'(bus.lo)}, {32'd0, 32'hA5A5A5A5});
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h13579BDF;
        @(posedge clk);
        #1 begin bus.hi_we = 1'b0; bus.lo_we = 1'b0; end
        @(negedge clk);
        check("mthi+mtlo", {32'(bus.hi), 32'(bus.lo)}, {32'h13579BDF, 32'h13579BDF});

        // start with write in the same idle cycle: write dropped
        bus.op = OP_MULTU; bus.rs_val = 32'd2; bus.rt_val = 32'd3; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; end
        @(negedge clk);
        check("start drops write", {32'(bus.hi), 32'(bus.lo)}, {32'h13579BDF, 32'h13579BDF});
        check("start accepted", 64'(bus.busy), 64'd1);
        wait_done(n, nb, sh);
        check("drop op result", {32'(bus.hi), 32'(bus.lo)}, {32'd0, 32'd6});

`ifdef MULDIV_STALL_CNT_EN
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        issue(OP_MULTU, 32'd5, 32'd5);
        repeat (3) @(posedge clk);
        #1 bus.hilo_rd = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.hilo_rd = 1'b0;
        @(negedge clk);
        check("stall_cycles 5", 64'(stall_cycles), 64'd5);
        wait_done(n, nb, sh);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("stall_cycles reset", 64'(stall_cycles), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
